// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port data RAM between two bus masters.
// Master 0 is the DLX data port and master 1 is a secondary master such as
// a framebuffer fetcher or DMA engine. Single-word reads and writes are
// serialised, with round-robin fairness when both masters request at once.
// A read waits for ram_rdata_valid. If it does not arrive in time, the read
// is aborted and returned with an error flag.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   mX_req             request, held stable with addr/we/wdata until mX_gnt
//   mX_addr            byte address; the word address is taken from bits
//                      [RAM_ADDR_WIDTH+1:2]
//   mX_we, mX_wdata    write enable (0 = read) and write data
//   mX_gnt             one-cycle pulse in the cycle the command reaches the RAM
//   mX_rvalid          one-cycle pulse carrying mX_rdata / mX_rerr
//   mX_rdata, mX_rerr  read data, and a timeout flag (rdata is 0 on a timeout)
//   ram_addr/we/wdata  RAM command; ram_we is high only in the issue cycle
//   ram_rdata(_valid)  RAM read response, looked at only while awaiting a read
module ram_arbiter #(
  parameter int unsigned RAM_ADDR_WIDTH = 10,
  parameter int unsigned TIMEOUT        = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m0_req,
  input  logic [31:0]               m0_addr,
  input  logic                      m0_we,
  input  logic [31:0]               m0_wdata,
  output logic                      m0_gnt,
  output logic                      m0_rvalid,
  output logic [31:0]               m0_rdata,
  output logic                      m0_rerr,
  input  logic                      m1_req,
  input  logic [31:0]               m1_addr,
  input  logic                      m1_we,
  input  logic [31:0]               m1_wdata,
  output logic                      m1_gnt,
  output logic                      m1_rvalid,
  output logic [31:0]               m1_rdata,
  output logic                      m1_rerr,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic                      ram_we,
  output logic [31:0]               ram_wdata,
  input  logic [31:0]               ram_rdata,
  input  logic                      ram_rdata_valid
);

  // The counter must be able to hold the value TIMEOUT (TIMEOUT >= 1).
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t             state;
  logic               owner;     // 0 = master 0, 1 = master 1
  logic               rr_ptr;    // preferred master when both request
  logic [CNT_W-1:0]   cnt;
  logic               ram_we_q;

  logic               win_any;
  logic               win_sel;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_wdata;
  logic               sel_we;
  logic               unused_addr;

  // Arbitration: a lone requester wins; on a tie, rr_ptr chooses.
  always_comb begin
    win_any = m0_req | m1_req;
    win_sel = 1'b0;
    if (m0_req && m1_req) begin
      win_sel = rr_ptr;
    end else if (m1_req) begin
      win_sel = 1'b1;
    end
    sel_addr  = win_sel ? m1_addr  : m0_addr;
    sel_wdata = win_sel ? m1_wdata : m0_wdata;
    sel_we    = win_sel ? m1_we    : m0_we;
  end

  // Byte-offset bits and address bits above the RAM range are not used.
  assign unused_addr = ^sel_addr;

  // Gate the registered write strobe with reset. A reset that lands on the
  // issue cycle of a write then stops the write from reaching the RAM.
  assign ram_we = ram_we_q & ~reset;

  // Arbiter FSM and all of its registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      rr_ptr    <= 1'b0;
      cnt       <= '0;
      ram_we_q  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      m0_rerr   <= 1'b0;
      m1_rerr   <= 1'b0;
    end else begin
      // Pulse outputs; read data is zero outside its rvalid cycle.
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      m0_rerr   <= 1'b0;
      m1_rerr   <= 1'b0;

      case (state)
        IDLE: begin
          if (win_any) begin
            owner     <= win_sel;
            ram_addr  <= sel_addr[RAM_ADDR_WIDTH+1:2];
            ram_wdata <= sel_wdata;
            ram_we_q  <= sel_we;
            m0_gnt    <= ~win_sel;
            m1_gnt    <= win_sel;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          ram_we_q <= 1'b0;
          rr_ptr   <= ~owner;
          if (ram_we_q) begin
            state <= IDLE;
          end else begin
            cnt   <= '0;
            state <= WAIT_RD;
          end
        end

        WAIT_RD: begin
          if (ram_rdata_valid) begin
            m0_rvalid <= ~owner;
            m1_rvalid <= owner;
            if (owner) begin
              m1_rdata <= ram_rdata;
            end else begin
              m0_rdata <= ram_rdata;
            end
            state <= IDLE;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            // Abort the read: flag the error and return zero data.
            m0_rvalid <= ~owner;
            m1_rvalid <= owner;
            m0_rerr   <= ~owner;
            m1_rerr   <= owner;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter, with a one-cycle-latency RAM model.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_rerr;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_rerr;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_rdata_valid;

  int          n_cmp = 0;
  int          n_err = 0;

  // RAM model: one-cycle read latency; model_en = 0 means no response ever.
  logic [31:0] mem [0:1023];
  logic        model_en;
  logic        force_valid;
  logic        model_valid = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    model_valid <= model_en && (m0_gnt || m1_gnt) && !ram_we;
    ram_rdata   <= mem[ram_addr];
  end
  assign ram_rdata_valid = model_valid | force_valid;

  ram_arbiter #(.RAM_ADDR_WIDTH(10), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rerr(m0_rerr),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rerr(m1_rerr),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_rdata_valid(ram_rdata_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulses"}, 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rerr, m1_rerr, ram_we}), 32'd0);
    check({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    check({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
  endtask

  // Checked on every cycle: one grant and one rvalid at most; idle read data is zero.
  always @(negedge clk) begin
    check("gnt_exclusive", 32'(m0_gnt & m1_gnt), 32'd0);
    check("rvalid_exclusive", 32'(m0_rvalid & m1_rvalid), 32'd0);
    if (!m0_rvalid) check("m0_quiet_rdata", 32'({m0_rerr}) | m0_rdata, 32'd0);
    if (!m1_rvalid) check("m1_quiet_rdata", 32'({m1_rerr}) | m1_rdata, 32'd0);
  end

  // Contention table: each master runs four mixed operations.
  logic [31:0] op0_addr [4], op0_wdata [4], op0_rexp [4];
  logic [31:0] op1_addr [4], op1_wdata [4], op1_rexp [4];
  logic        op0_we [4], op1_we [4];
  int          i0, i1, g_cnt, rd_done;
  logic [31:0] exp0, exp1;
  logic        quiet;

  initial begin
    reset = 1'b1; force_valid = 1'b0; model_en = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    op0_addr  = '{32'h20, 32'h20, 32'h40, 32'h40};
    op0_we    = '{1'b1, 1'b0, 1'b1, 1'b0};
    op0_wdata = '{32'hA0A0A0A0, 32'h0, 32'hC0C0C0C0, 32'h0};
    op0_rexp  = '{32'h0, 32'hA0A0A0A0, 32'h0, 32'hC0C0C0C0};
    op1_addr  = '{32'h10, 32'h30, 32'h30, 32'h50};
    op1_we    = '{1'b0, 1'b1, 1'b0, 1'b1};
    op1_wdata = '{32'h0, 32'hB1B1B1B1, 32'h0, 32'hD1D1D1D1};
    op1_rexp  = '{32'hDEADBEEF, 32'h0, 32'hB1B1B1B1, 32'h0};
    tick(); tick(); tick();
    check_all_zero("reset");
    reset = 1'b0;

    // Single write from m0.
    m0_addr = 32'h10; m0_we = 1'b1; m0_wdata = 32'hDEADBEEF; m0_req = 1'b1;
    tick();
    check("wr_m0_gnt", 32'(m0_gnt), 32'd1);
    check("wr_m1_gnt", 32'(m1_gnt), 32'd0);
    check("wr_ram_we", 32'(ram_we), 32'd1);
    check("wr_ram_addr", 32'(ram_addr), 32'd4);
    check("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
    m0_req = 1'b0;
    tick();
    check("wr_gnt_drop", 32'(m0_gnt), 32'd0);
    check("wr_we_drop", 32'(ram_we), 32'd0);

    // Read back: granted at once (the FSM is idle), response three edges after the request.
    m0_we = 1'b0; m0_req = 1'b1;
    tick();
    check("rd_m0_gnt", 32'(m0_gnt), 32'd1);
    check("rd_ram_we", 32'(ram_we), 32'd0);
    check("rd_ram_addr", 32'(ram_addr), 32'd4);
    m0_req = 1'b0;
    tick();
    check("rd_rvalid_early", 32'(m0_rvalid), 32'd0);
    tick();
    check("rd_m0_rvalid", 32'(m0_rvalid), 32'd1);
    check("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("rd_m0_rerr", 32'(m0_rerr), 32'd0);
    check("rd_m1_rvalid", 32'(m1_rvalid), 32'd0);
    tick();
    check("rd_rvalid_pulse", 32'(m0_rvalid), 32'd0);

    // Both masters request continuously: grants must alternate, starting with m0.
    do_reset();
    i0 = 0; i1 = 0; g_cnt = 0; rd_done = 0; exp0 = '0; exp1 = '0;
    m0_addr = op0_addr[0]; m0_we = op0_we[0]; m0_wdata = op0_wdata[0]; m0_req = 1'b1;
    m1_addr = op1_addr[0]; m1_we = op1_we[0]; m1_wdata = op1_wdata[0]; m1_req = 1'b1;
    for (int c = 0; c < 200 && !(g_cnt == 8 && rd_done == 4); c++) begin
      tick();
      if (m0_rvalid) begin
        check("rr_m0_rdata", m0_rdata, exp0);
        check("rr_m0_rerr", 32'(m0_rerr), 32'd0);
        rd_done++;
      end
      if (m1_rvalid) begin
        check("rr_m1_rdata", m1_rdata, exp1);
        check("rr_m1_rerr", 32'(m1_rerr), 32'd0);
        rd_done++;
      end
      if (m0_gnt || m1_gnt) begin
        check($sformatf("rr_order_%0d", g_cnt), 32'(m1_gnt), 32'(g_cnt % 2));
        g_cnt++;
        if (m0_gnt) begin
          check("rr_m0_we", 32'(ram_we), 32'(op0_we[i0]));
          exp0 = op0_rexp[i0];
          i0++;
          if (i0 < 4) begin
            m0_addr = op0_addr[i0]; m0_we = op0_we[i0]; m0_wdata = op0_wdata[i0];
          end else m0_req = 1'b0;
        end else begin
          check("rr_m1_we", 32'(ram_we), 32'(op1_we[i1]));
          exp1 = op1_rexp[i1];
          i1++;
          if (i1 < 4) begin
            m1_addr = op1_addr[i1]; m1_we = op1_we[i1]; m1_wdata = op1_wdata[i1];
          end else m1_req = 1'b0;
        end
      end
    end
    check("rr_grants", 32'(g_cnt), 32'd8);
    check("rr_reads", 32'(rd_done), 32'd4);
    m0_req = 1'b0; m1_req = 1'b0;
    tick(); tick();

    // Read timeout: the RAM never answers.
    model_en = 1'b0;
    m0_addr = 32'h10; m0_we = 1'b0; m0_req = 1'b1;
    tick();
    check("to_m0_gnt", 32'(m0_gnt), 32'd1);
    m0_req = 1'b0;
    tick();
    quiet = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (m0_rvalid || m1_rvalid) quiet = 1'b0;
    end
    check("to_no_early_rvalid", 32'(quiet), 32'd1);
    tick();
    check("to_m0_rvalid", 32'(m0_rvalid), 32'd1);
    check("to_m0_rerr", 32'(m0_rerr), 32'd1);
    check("to_m0_rdata", m0_rdata, 32'd0);
    check("to_m1_rvalid", 32'(m1_rvalid), 32'd0);
    // A normal read completes after the timeout.
    model_en = 1'b1;
    m1_addr = 32'h30; m1_we = 1'b0; m1_req = 1'b1;
    tick();
    check("post_to_m1_gnt", 32'(m1_gnt), 32'd1);
    m1_req = 1'b0;
    tick(); tick();
    check("post_to_m1_rvalid", 32'(m1_rvalid), 32'd1);
    check("post_to_m1_rdata", m1_rdata, 32'hB1B1B1B1);
    check("post_to_m1_rerr", 32'(m1_rerr), 32'd0);

    // Reset while waiting on a read: no response, and a late rdata_valid is ignored.
    model_en = 1'b0;
    m0_addr = 32'h10; m0_we = 1'b0; m0_req = 1'b1;
    tick();
    m0_req = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check_all_zero("rst_wait");
    reset = 1'b0;
    force_valid = 1'b1;
    tick();
    force_valid = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (m0_rvalid || m1_rvalid || m0_gnt || m1_gnt) quiet = 1'b0;
    end
    check("rst_wait_no_rvalid", 32'(quiet), 32'd1);
    check_all_zero("rst_wait_after");

    // Reset during the issue cycle of a write suppresses the RAM write strobe.
    model_en = 1'b1;
    m0_addr = 32'h60; m0_we = 1'b1; m0_wdata = 32'h12345678; m0_req = 1'b1;
    tick();
    check("rst_issue_we_before", 32'(ram_we), 32'd1);
    m0_req = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_issue_we_gated", 32'(ram_we), 32'd0);
    tick();
    reset = 1'b0;

    // m0 wins while m1 also requests; m1 then withdraws and is never granted.
    m0_addr = 32'h70; m0_we = 1'b1; m0_wdata = 32'h00000077; m0_req = 1'b1;
    m1_addr = 32'h10; m1_we = 1'b0; m1_req = 1'b1;
    tick();
    check("drop_m0_gnt", 32'(m0_gnt), 32'd1);
    check("drop_m1_gnt", 32'(m1_gnt), 32'd0);
    m0_req = 1'b0; m1_req = 1'b0;
    // A brief pulse on m1_req that ends before the clock edge must not be sampled.
    m1_req = 1'b1;
    #2;
    m1_req = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (m1_gnt || m1_rvalid || m0_gnt) quiet = 1'b0;
    end
    check("drop_no_m1_activity", 32'(quiet), 32'd1);
    // Only the m0 write took place: read it back.
    m0_we = 1'b0; m0_req = 1'b1;
    tick();
    check("drop_rb_gnt", 32'(m0_gnt), 32'd1);
    m0_req = 1'b0;
    tick(); tick();
    check("drop_rb_rvalid", 32'(m0_rvalid), 32'd1);
    check("drop_rb_rdata", m0_rdata, 32'h00000077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master arbiter that shares the single-port data RAM between the DLX data port (master 0) and a secondary bus master (master 1, e.g. a VGA framebuffer fetcher or DMA engine). It sits between the masters and the `ram` instance. It serialises single-word read and write transactions with round-robin fairness. It tracks the RAM's registered read latency through `rdata_valid`, returns read data to the owning master, and aborts reads that exceed a timeout.

## Interface
Parameters:
- RAM_ADDR_WIDTH, 10, RAM word-address width; RAM address = master byte address bits [RAM_ADDR_WIDTH+1:2]
- TIMEOUT, 15, max cycles in WAIT_RD before a read is aborted (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  transaction request; held with addr/we/wdata stable until gnt
- m0_addr / m1_addr  in  32  byte address; bits [1:0] ignored
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_wdata / m1_wdata  in  32  write data
- m0_gnt / m1_gnt  out  1  one-cycle pulse: request accepted and issued to RAM this cycle
- m0_rvalid / m1_rvalid  out  1  one-cycle pulse: read response on mX_rdata / mX_rerr
- m0_rdata / m1_rdata  out  32  read data, valid only with rvalid
- m0_rerr / m1_rerr  out  1  read timed out, valid only with rvalid (rdata = 0)
- ram_addr  out  RAM_ADDR_WIDTH  registered RAM word address
- ram_we  out  1  RAM write enable, asserted only in ISSUE
- ram_wdata  out  32  registered RAM write data
- ram_rdata  in  32  RAM read data
- ram_rdata_valid  in  1  RAM read data valid

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD. Registers: state, owner (0/1), rr_ptr, timeout counter (width $clog2(TIMEOUT+1)), all outputs.
- IDLE:
  - if neither req: stay.
  - if exactly one req: that master wins.
  - if both req: master selected by rr_ptr wins.
  - On a win, register ram_addr/ram_wdata/ram_we(=mX_we) and owner, set the winner's gnt for next cycle, then go to ISSUE.
- ISSUE:
  - gnt pulse of owner is high; ram_we high iff write.
  - rr_ptr ← other master.
  - Write: go to IDLE.
  - Read: go to WAIT_RD, counter ← 0.
- WAIT_RD:
  - ram_addr held; ram_we = 0.
  - If ram_rdata_valid: next cycle owner rvalid = 1, owner rdata = ram_rdata (registered), rerr = 0; go to IDLE.
  - Else counter++. When counter reaches TIMEOUT: next cycle owner rvalid = 1, rerr = 1, rdata = 0; go to IDLE.
- ram_rdata_valid outside WAIT_RD is ignored.
- Requests are sampled only in IDLE. A request dropped before gnt creates no transaction. After gnt the transaction is committed regardless of req.
- Non-owner outputs stay 0 at all times. At most one gnt and at most one rvalid are high in any cycle.
- rr_ptr reset value favours master 0 (CPU).

## Timing
- Reset (synchronous, active-high) forces: state = IDLE, rr_ptr = 0, counter = 0; all gnt/rvalid/rerr = 0, all rdata = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0.
- Reset mid-transaction aborts it: no rvalid is produced, and a pending RAM write in ISSUE is suppressed (ram_we = 0 in the reset cycle).
- Req seen high in IDLE at cycle N gives gnt and RAM command in cycle N+1.
- Write occupancy: 2 cycles. Back-to-back writes from one master: gnt every 2 cycles.
- Read with a 1-cycle RAM (valid in first WAIT_RD cycle N+2) gives rvalid in cycle N+3. Read occupancy: 3 cycles.
- Timed-out read: rvalid/rerr in cycle N+2+TIMEOUT+1.
- Both masters requesting continuously: grants alternate 0,1,0,1…; neither master waits more than one other transaction.

## Test plan
- Reset, then m0 write addr 0x10, data 0xDEADBEEF → m0_gnt and ram_we high in the same cycle, ram_addr = 4, ram_wdata = 0xDEADBEEF, FSM back to IDLE the next cycle.
- m0 read addr 0x10 with a RAM model of 1-cycle latency holding 0xDEADBEEF → m0_rvalid exactly 3 cycles after req is sampled, m0_rdata = 0xDEADBEEF, m0_rerr = 0, m1 outputs stay 0.
- Both reqs held high for 8 transactions (mixed read/write) → grant order 0,1,0,1…; first grant goes to m0 after reset; gnt is never high for both masters.
- Read with ram_rdata_valid tied low, TIMEOUT = 15 → owner rvalid = 1, rerr = 1, rdata = 0 exactly 16 cycles after entering WAIT_RD; the next request is then served normally.
- Assert reset in WAIT_RD, then deassert → no rvalid pulse, all outputs 0; a late ram_rdata_valid is ignored.
- m1 raises req then drops it in the same IDLE cycle that m0 wins → only the m0 transaction occurs, and m1_gnt never pulses.
